hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage MIPS core. Decides every cycle whether PC, IF/ID, ID/EX,
//  EX/MEM, MEM/WB advance, hold, bubble or flush. Covers load-use stalls, taken beq/j flushes and

---
 rtl/hazard_stall_ctrl.sv | 155 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Pipeline sequencer for the 5-stage core. It decides each cycle
//               whether the pipeline advances, stalls, bubbles, flushes or
//               freezes on a slow data-memory access.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             idex_memrd_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             branch_i,
    input  logic             equal_i,
    input  logic             jump_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_hold_o,
    output logic             memwb_bubble_o,
    output logic             dmem_strobe_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_wait_last = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic             r_timeout;
    logic             w_set_timeout;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_lu;
    logic w_redirect;
    logic w_adv_pc;
    logic w_adv_flush;
    logic w_adv_bubble;

    assign w_lu = idex_memrd_i && (idex_rt_i != 5'd0) &&
                  ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
    assign w_redirect = jump_i || (branch_i && equal_i);

    // Decision used whenever the pipeline is not frozen: load-use outranks
    // redirect because the branch compare would see stale operands.
    always_comb begin
        w_adv_pc     = 1'b1;
        w_adv_flush  = 1'b0;
        w_adv_bubble = 1'b0;
        if (w_lu) begin
            w_adv_pc     = 1'b0;
            w_adv_bubble = 1'b1;
        end else if (w_redirect) begin
            w_adv_flush  = 1'b1;
        end
    end

    always_comb begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        exmem_hold_o   = 1'b0;
        memwb_bubble_o = 1'b0;
        dmem_strobe_o  = 1'b0;
        w_next_state   = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_set_timeout  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (dmem_req_i && !dmem_ack_i) begin
                    exmem_hold_o   = 1'b1;
                    memwb_bubble_o = 1'b1;
                    dmem_strobe_o  = 1'b1;
                    w_wait_cnt_nxt = '0;
                    w_next_state   = S_MEM_WAIT;
                end else begin
                    pc_write_o    = w_adv_pc;
                    ifid_write_o  = w_adv_pc;
                    ifid_flush_o  = w_adv_flush;
                    idex_bubble_o = w_adv_bubble;
                    dmem_strobe_o = dmem_req_i;
                end
            end
            S_MEM_WAIT: begin
                dmem_strobe_o = 1'b1;
                if (dmem_ack_i || (r_wait_cnt == c_wait_last)) begin
                    pc_write_o     = w_adv_pc;
                    ifid_write_o   = w_adv_pc;
                    ifid_flush_o   = w_adv_flush;
                    idex_bubble_o  = w_adv_bubble;
                    // An abandoned access must not write back garbage.
                    memwb_bubble_o = !dmem_ack_i;
                    w_set_timeout  = !dmem_ack_i;
                    w_wait_cnt_nxt = '0;
                    w_next_state   = S_RUN;
                end else begin
                    exmem_hold_o   = 1'b1;
                    memwb_bubble_o = 1'b1;
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
            if ((r_state != S_IDLE) && !pc_write_o && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign timeout_o   = r_timeout;
    assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Table-driven directed bench for hazard_stall_ctrl, plus a
//               stall-counter saturation sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int c_timeout = 4;
    localparam int c_cnt_w   = 8;

    typedef struct {
        logic       rst;
        logic       start;
        logic       memrd;
        logic [4:0] idex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       eq;
        logic       jmp;
        logic       req;
        logic       ack;
        logic [6:0] exp_ctl;   // {pc,ifid,flush,bubble,hold,memwb,strobe}
        logic       exp_to;
        logic [7:0] exp_cnt;
    } vec_t;

    logic r_clk = 1'b0;
    logic r_rst, r_start, r_memrd, r_br, r_eq, r_jmp, r_req, r_ack;
    logic [4:0] r_idex_rt, r_rs, r_rt;
    logic w_pc, w_ifid, w_flush, w_bubble, w_hold, w_memwb, w_strobe, w_to;
    logic [c_cnt_w-1:0] w_cnt;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];

    always #5 r_clk = ~r_clk;

    hazard_stall_ctrl #(.MEM_TIMEOUT(c_timeout), .CNT_W(c_cnt_w)) u_dut (
        .clk_i         (r_clk),
        .rst_i         (r_rst),
        .start_i       (r_start),
        .idex_memrd_i  (r_memrd),
        .idex_rt_i     (r_idex_rt),
        .ifid_rs_i     (r_rs),
        .ifid_rt_i     (r_rt),
        .branch_i      (r_br),
        .equal_i       (r_eq),
        .jump_i        (r_jmp),
        .dmem_req_i    (r_req),
        .dmem_ack_i    (r_ack),
        .pc_write_o    (w_pc),
        .ifid_write_o  (w_ifid),
        .ifid_flush_o  (w_flush),
        .idex_bubble_o (w_bubble),
        .exmem_hold_o  (w_hold),
        .memwb_bubble_o(w_memwb),
        .dmem_strobe_o (w_strobe),
        .timeout_o     (w_to),
        .stall_cnt_o   (w_cnt)
    );

    function automatic vec_t mk(input logic rst, input logic start, input logic memrd,
                                input logic [4:0] idex_rt, input logic [4:0] rs,
                                input logic [4:0] rt, input logic br, input logic eq,
                                input logic jmp, input logic req, input logic ack,
                                input logic [6:0] ctl, input logic to, input logic [7:0] cnt);
        vec_t v;
        v.rst = rst; v.start = start; v.memrd = memrd; v.idex_rt = idex_rt;
        v.rs = rs; v.rt = rt; v.br = br; v.eq = eq; v.jmp = jmp;
        v.req = req; v.ack = ack; v.exp_ctl = ctl; v.exp_to = to; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        r_rst = v.rst; r_start = v.start; r_memrd = v.memrd; r_idex_rt = v.idex_rt;
        r_rs = v.rs; r_rt = v.rt; r_br = v.br; r_eq = v.eq; r_jmp = v.jmp;
        r_req = v.req; r_ack = v.ack;
    endtask

    task automatic check(input string name, input logic [6:0] exp_ctl,
                         input logic exp_to, input logic [7:0] exp_cnt);
        logic [6:0] act;
        act = {w_pc, w_ifid, w_flush, w_bubble, w_hold, w_memwb, w_strobe};
        n_checks++;
        if ({act, w_to} !== {exp_ctl, exp_to}) begin
            n_errors++;
            $display("FAIL %s ctl/timeout: got %b/%b expected %b/%b", name, act, w_to, exp_ctl, exp_to);
        end
        n_checks++;
        if (w_cnt !== exp_cnt) begin
            n_errors++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", name, w_cnt, exp_cnt);
        end
    endtask

    initial begin
        // rst st mr irt rs rt br eq j rq ak  ctl        to cnt
        vecs.push_back(mk(0,1,0,0,0,0,0,0,0,0,0, 7'b0000000,0,0));  // IDLE
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 7'b1100000,0,0));  // RUN advance
        vecs.push_back(mk(0,0,1,8,8,1,0,0,0,0,0, 7'b0001000,0,0));  // load-use on rs
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 7'b1100000,0,1));
        vecs.push_back(mk(0,0,1,0,0,0,0,0,0,0,0, 7'b1100000,0,1));  // $zero never stalls
        vecs.push_back(mk(0,0,1,9,3,9,0,0,0,0,0, 7'b0001000,0,1));  // load-use on rt
        vecs.push_back(mk(0,0,1,9,4,5,0,0,0,0,0, 7'b1100000,0,2));  // no register match
        vecs.push_back(mk(0,0,0,0,0,0,1,1,0,0,0, 7'b1110000,0,2));  // beq taken
        vecs.push_back(mk(0,0,0,0,0,0,1,0,0,0,0, 7'b1100000,0,2));  // beq not taken
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,0,0, 7'b1110000,0,2));  // jump
        vecs.push_back(mk(0,0,1,7,7,0,1,1,0,0,0, 7'b0001000,0,2));  // beq + load-use
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 7'b1100000,0,3));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,1, 7'b1100001,0,3));  // req+ack same cycle
        vecs.push_back(mk(0,0,1,6,6,0,0,0,0,1,1, 7'b0001001,0,3));  // req+ack with load-use
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 7'b0000111,0,4));  // freeze 1
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 7'b0000111,0,5));  // freeze 2
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 7'b0000111,0,6));  // freeze 3
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,1, 7'b1100001,0,7));  // ack releases
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 7'b1100000,0,7));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 7'b0000111,0,7));
        vecs.push_back(mk(0,0,1,5,5,0,0,0,0,1,1, 7'b0001001,0,8));  // ack release into load-use
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 7'b1100000,0,9));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 7'b0000111,0,9));  // timeout run
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 7'b0000111,0,10));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 7'b0000111,0,11));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 7'b0000111,0,12));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 7'b1100011,0,13)); // abort cycle
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 7'b1100000,1,13)); // sticky timeout
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 7'b1100000,1,13));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 7'b0000111,1,13));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,1,0, 7'b0000111,1,14)); // reset mid-wait
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,0, 7'b0000000,0,0));  // IDLE, strobe gone
        vecs.push_back(mk(0,1,0,0,0,0,0,0,0,0,0, 7'b0000000,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 7'b1100000,0,0));

        drive(mk(1,0,0,0,0,0,0,0,0,0,0, 7'b0,0,0));
        repeat (2) @(posedge r_clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #4;
            check($sformatf("vec%0d", i), vecs[i].exp_ctl, vecs[i].exp_to, vecs[i].exp_cnt);
            @(posedge r_clk);
            #1;
        end

        // Saturation: hold a load-use stall for 300 cycles.
        drive(mk(0,0,1,3,3,0,0,0,0,0,0, 7'b0,0,0));
        for (int i = 0; i < 300; i++) begin
            #4;
            if (i == 254) check("sat_254", 7'b0001000, 0, 8'd254);
            if (i == 255) check("sat_255", 7'b0001000, 0, 8'd255);
            @(posedge r_clk);
            #1;
        end
        #4;
        check("sat_300", 7'b0001000, 0, 8'd255);
        @(posedge r_clk);
        #1;
        drive(mk(0,0,0,0,0,0,0,0,0,0,0, 7'b0,0,0));
        #4;
        check("sat_release", 7'b1100000, 0, 8'd255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
